match_judge: RTL and testbench

MATCH_JUDGE -- requirements
Module: match_judge

---
 rtl/match_judge_if.sv | 26 ++
 rtl/match_judge.sv | 147 ++++++++++++++
 tb/tb_match_judge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_judge_if.sv
// match_judge_if: player inputs, board colors and game status shared by the judge and its driver.
interface match_judge_if;
    logic        confirm;
    logic [2:0]  secim1;
    logic [2:0]  secim2;
    logic [2:0]  secim3;
    logic [2:0]  secim4;
    logic [2:0]  es1;
    logic [2:0]  es2;
    logic [2:0]  es3;
    logic [2:0]  es4;
    logic [23:0] colors;
    logic [3:0]  step;
    logic [7:0]  open_mask;
    logic        mismatch;
    logic        win;
    logic [7:0]  tries;
    modport master (
        output confirm, secim1, secim2, secim3, secim4, es1, es2, es3, es4, colors,
        input  step, open_mask, mismatch, win, tries
    );
    modport slave (
        input  confirm, secim1, secim2, secim3, secim4, es1, es2, es3, es4, colors,
        output step, open_mask, mismatch, win, tries
    );
endinterface

// File: rtl/match_judge.sv
// match_judge: debounced select button driving a four-pair memory game judge.
module match_judge #(
    parameter int DEB_CYCLES  = 250000,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic         clk25MHz,
    input  logic         rst,
    match_judge_if.slave io_bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {S_PICK1, S_PICK2, S_CHECK, S_HOLD, S_DONE} state_t;

    logic [1:0]    r_sync;
    logic [1:0]    r_fill;
    logic          r_deb;
    logic          r_deb_q;
    logic          r_armed;
    logic [DW-1:0] r_deb_cnt;
    logic          w_pulse;

    // r_armed needs a real low sample after reset, so a button held through reset never fires
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_sync    <= '0;
            r_fill    <= '0;
            r_deb     <= 1'b0;
            r_deb_q   <= 1'b0;
            r_armed   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync  <= {r_sync[0], io_bus.confirm};
            r_fill  <= {r_fill[0], 1'b1};
            r_deb_q <= r_deb;
            r_armed <= r_armed | (r_fill[1] & ~r_sync[1]);
            if (r_sync[1] == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb     <= r_sync[1];
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    assign w_pulse = r_deb & ~r_deb_q & r_armed;

    state_t        r_state, w_state;
    logic [1:0]    r_p, w_p;
    logic [2:0]    r_a1, w_a1, r_a2, w_a2;
    logic [7:0]    r_matched, w_matched;
    logic [7:0]    r_tries, w_tries;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt;
    logic [2:0]    w_col [8];
    logic [2:0]    w_sec;
    logic [2:0]    w_es;
    logic [7:0]    w_oh1;
    logic [7:0]    w_oh2;
    logic [3:0]    w_p3;

    always_comb begin
        for (int i = 0; i < 8; i++) w_col[i] = io_bus.colors[3*i +: 3];
    end

    assign w_sec = (r_p == 2'd0) ? io_bus.secim1 : (r_p == 2'd1) ? io_bus.secim2 :
                   (r_p == 2'd2) ? io_bus.secim3 : io_bus.secim4;
    assign w_es  = (r_p == 2'd0) ? io_bus.es1 : (r_p == 2'd1) ? io_bus.es2 :
                   (r_p == 2'd2) ? io_bus.es3 : io_bus.es4;
    assign w_oh1 = 8'd1 << r_a1;
    assign w_oh2 = 8'd1 << r_a2;
    assign w_p3  = {1'b0, r_p, 1'b0} + {2'b00, r_p};

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_state    <= S_PICK1;
            r_p        <= '0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_matched  <= '0;
            r_tries    <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_p        <= w_p;
            r_a1       <= w_a1;
            r_a2       <= w_a2;
            r_matched  <= w_matched;
            r_tries    <= w_tries;
            r_hold_cnt <= w_hold_cnt;
        end
    end

    // Pulses outside PICK1/PICK2 fall through untouched, so nothing is queued
    always_comb begin
        w_state    = r_state;
        w_p        = r_p;
        w_a1       = r_a1;
        w_a2       = r_a2;
        w_matched  = r_matched;
        w_tries    = r_tries;
        w_hold_cnt = r_hold_cnt;
        case (r_state)
            S_PICK1: if (w_pulse) begin
                w_a1    = w_sec;
                w_state = S_PICK2;
            end
            S_PICK2: if (w_pulse && w_es != r_a1) begin
                w_a2    = w_es;
                w_state = S_CHECK;
            end
            S_CHECK: begin
                w_tries    = r_tries + 8'(r_tries != 8'hFF);
                w_hold_cnt = '0;
                if (w_col[r_a1] == w_col[r_a2]) begin
                    w_matched = r_matched | w_oh1 | w_oh2;
                    w_p       = r_p + 2'd1;
                    w_state   = (r_p == 2'd3) ? S_DONE : S_PICK1;
                    w_a1      = '0;
                    w_a2      = '0;
                end else begin
                    w_state = S_HOLD;
                end
            end
            S_HOLD: if (r_hold_cnt == HOLD_LAST) begin
                w_state = S_PICK1;
                w_a1    = '0;
                w_a2    = '0;
            end else begin
                w_hold_cnt = r_hold_cnt + HW'(1);
            end
            default: ;
        endcase
    end

    assign io_bus.step      = (r_state == S_DONE) ? 4'd12 :
                              w_p3 + ((r_state == S_PICK1) ? 4'd0 : (r_state == S_PICK2) ? 4'd1 : 4'd2);
    assign io_bus.open_mask = (r_state == S_DONE) ? 8'hFF :
                              r_matched | ((r_state != S_PICK1) ? w_oh1 : 8'd0) |
                              ((r_state == S_CHECK || r_state == S_HOLD) ? w_oh2 : 8'd0);
    assign io_bus.mismatch  = (r_state == S_HOLD);
    assign io_bus.win       = (r_state == S_DONE);
    assign io_bus.tries     = r_tries;
endmodule

// File: tb/tb_match_judge.sv
// tb_match_judge: lockstep game model feeds an expected-change queue; a monitor checks every DUT output change.
module tb_match_judge;
    localparam int DEB  = 4;
    localparam int HOLD = 10;

    typedef struct packed {
        logic [3:0] step;
        logic [7:0] mask;
        logic       mm;
        logic       win;
        logic [7:0] tries;
    } snap_t;

    typedef struct packed {
        snap_t       s;
        int unsigned cyc;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        conf = 1'b0;
    logic [2:0]  sec [4];
    logic [2:0]  esv [4];
    logic [23:0] colors = '0;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    snap_t       mon_last = '0;
    exp_t        exp_q [$];

    match_judge_if bus ();
    assign bus.confirm = conf;
    assign bus.secim1  = sec[0];
    assign bus.secim2  = sec[1];
    assign bus.secim3  = sec[2];
    assign bus.secim4  = sec[3];
    assign bus.es1     = esv[0];
    assign bus.es2     = esv[1];
    assign bus.es3     = esv[2];
    assign bus.es4     = esv[3];
    assign bus.colors  = colors;

    match_judge #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk25MHz(clk),
        .rst(rst),
        .io_bus(bus)
    );

    always #20 clk = ~clk;

    // Reference model: raw history gives the synchronized/debounced level, game follows the pick/check/hold rules
    bit          raw_q [$];
    bit          m_deb, m_armed, m_pulse;
    int          since_rst, ph, p;
    logic [2:0]  a1, a2;
    logic [7:0]  matched, tries;
    int unsigned hold_end;
    snap_t       m_last = '0;

    function automatic logic [2:0] col(logic [2:0] i);
        return colors[3*int'(i) +: 3];
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.step  = (ph == 4) ? 4'd12 : 4'(3 * p + ((ph == 0) ? 0 : (ph == 1) ? 1 : 2));
        s.mask  = (ph == 4) ? 8'hFF :
                  matched | ((ph >= 1) ? 8'd1 << a1 : 8'd0) | ((ph >= 2) ? 8'd1 << a2 : 8'd0);
        s.mm    = (ph == 3);
        s.win   = (ph == 4);
        s.tries = tries;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        return snap_t'({bus.step, bus.open_mask, bus.mismatch, bus.win, bus.tries});
    endfunction

    always @(posedge clk) begin
        bit    prev, diff;
        snap_t s;
        exp_t  e;
        cyc++;
        if (rst) begin
            raw_q.delete();
            repeat (DEB + 3) raw_q.push_back(1'b0);
            m_deb = 0; m_armed = 0; m_pulse = 0; since_rst = 0;
            ph = 0; p = 0; a1 = '0; a2 = '0; matched = '0; tries = '0;
        end else begin
            since_rst++;
            case (ph)
                0: if (m_pulse) begin a1 = sec[p]; ph = 1; end
                1: if (m_pulse && esv[p] != a1) begin a2 = esv[p]; ph = 2; end
                2: begin
                    if (tries != 8'hFF) tries = tries + 8'd1;
                    if (col(a1) == col(a2)) begin
                        matched = matched | (8'd1 << a1) | (8'd1 << a2);
                        p = p + 1;
                        ph = (p == 4) ? 4 : 0;
                    end else begin
                        ph = 3;
                        hold_end = cyc + HOLD;
                    end
                end
                3: if (cyc == hold_end) ph = 0;
                default: ;
            endcase
            raw_q.push_back(conf);
            void'(raw_q.pop_front());
            prev = m_deb;
            diff = 1;
            for (int j = 0; j < DEB; j++) if (raw_q[raw_q.size() - 3 - j] == m_deb) diff = 0;
            if (diff) m_deb = ~m_deb;
            if (since_rst >= 3 && !raw_q[raw_q.size() - 3]) m_armed = 1;
            m_pulse = m_deb & ~prev & m_armed;
        end
        s = model_snap();
        if (s != m_last) begin
            e.s = s;
            e.cyc = cyc;
            exp_q.push_back(e);
            m_last = s;
        end
    end

    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        if (mon_en) begin
            cur = dut_snap();
            if (cur !== mon_last) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.s !== cur || e.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL output_change: got %h at cycle %0d, required %h at cycle %0d",
                                 cur, cyc, e.s, e.cyc);
                    end
                end
                mon_last = cur;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic press(int hi, int lo);
        conf = 1'b1;
        tick(hi);
        conf = 1'b0;
        tick(lo);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    function automatic logic [23:0] pair_colors(bit distinct);
        logic [23:0] c;
        for (int i = 0; i < 8; i++) c[3*i +: 3] = distinct ? 3'(i) : 3'(i % 4);
        return c;
    endfunction

    initial begin
        int run;
        int k;
        for (int i = 0; i < 4; i++) begin
            sec[i] = '0;
            esv[i] = '0;
        end
        colors = pair_colors(1'b0);
        conf = 1'b1;
        tick(3);
        mon_en = 1'b1;
        chk("reset_state", 32'(dut_snap()), 32'(snap_t'('0)));
        rst = 1'b0;
        tick(20);
        conf = 1'b0;
        tick(12);
        press(3, 8);
        sec[0] = 3'd0;
        esv[0] = 3'd4;
        conf = 1'b1;
        tick(2);
        repeat (5) begin
            conf = ~conf;
            tick(2);
        end
        conf = 1'b1;
        tick(20);
        conf = 1'b0;
        tick(12);
        press(8, 12);
        chk("pair1_match", 32'(dut_snap()), 32'(snap_t'({4'd3, 8'h11, 1'b0, 1'b0, 8'd1})));
        sec[1] = 3'd1;
        press(8, 12);
        esv[1] = 3'd1;
        press(8, 12);
        esv[1] = 3'd5;
        press(8, 12);
        sec[2] = 3'd2;
        esv[2] = 3'd3;
        press(8, 12);
        press(4, 4);
        press(4, 30);
        esv[2] = 3'd6;
        press(8, 12);
        press(8, 12);
        sec[3] = 3'd3;
        esv[3] = 3'd7;
        press(8, 12);
        press(8, 12);
        press(8, 12);
        press(8, 12);
        chk("game_won", 32'(dut_snap()), 32'(snap_t'({4'd12, 8'hFF, 1'b0, 1'b1, 8'd5})));
        pulse_rst();
        tick(2);
        press(8, 12);
        press(8, 12);
        sec[1] = 3'd1;
        esv[1] = 3'd2;
        press(8, 12);
        conf = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        conf = 1'b0;
        chk("reset_in_hold", 32'(dut_snap()), 32'(snap_t'('0)));
        tick(12);
        colors = pair_colors(1'b1);
        sec[0] = 3'd0;
        esv[0] = 3'd1;
        repeat (900) press(4, 4);
        chk("tries_saturate", 32'(bus.tries), 32'd255);
        colors = pair_colors(1'b0);
        pulse_rst();
        run = 0;
        for (int c = 0; c < 20000; c++) begin
            if (run == 0) begin
                conf = ~conf;
                run = int'($urandom_range(1, 10));
            end
            run--;
            if ($urandom_range(0, 15) == 0) begin
                k = int'($urandom_range(0, 3));
                sec[k] = 3'($urandom_range(0, 7));
                esv[k] = ($urandom_range(0, 2) != 0) ? sec[k] ^ 3'd4 : 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 2999) == 0) begin
                rst = 1'b1;
                colors = ($urandom_range(0, 1) != 0) ? pair_colors(1'b0) : 24'($urandom());
            end else begin
                rst = 1'b0;
            end
            tick(1);
        end
        rst = 1'b0;
        conf = 1'b0;
        tick(30);
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
